// File: rtl/mips_cpu_muldiv_iter.sv
// Iterative MIPS multiply/divide engine: shift-add MULT/MULTU and restoring
// DIV/DIVU over 32 CALC cycles, then one FIXUP cycle for sign correction.
// Results are registered into hi_out/lo_out with a one-cycle done pulse.
module mips_cpu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // op[0]: 1 = multiply, 0 = divide; op[1]: 1 = signed
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_mul_q, is_mul_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // datapath intermediates
    logic               accept;
    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] mul_addend;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   rem_fix;

    assign busy   = (state_q == S_CALC) || (state_q == S_FIXUP);
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

    // A new operation is sampled in IDLE, or in DONE for back-to-back issue
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign a_neg  = op[1] & a[WIDTH-1];
    assign b_neg  = op[1] & b[WIDTH-1];

    // One shift-add step (LSB-first) and one restoring-divide step
    always_comb begin
        mul_addend = b_mag_q[cnt_q] ? ({{WIDTH{1'b0}}, a_mag_q} << cnt_q) : '0;
        mul_next   = acc_q + mul_addend;

        // next dividend bit comes in MSB-first as the counter advances
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], a_mag_q[LAST - cnt_q]};
        trial  = rem_sh - {1'b0, b_mag_q};
        if (trial[WIDTH]) begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        quo = acc_q[WIDTH-1:0];
        rem = acc_q[2*WIDTH-1:WIDTH];
        // remainder takes the dividend's sign; with a zero divisor rem == |a|,
        // so this also restores the raw sampled a for the divide-by-zero result
        rem_fix = sign_a_q ? (~rem + 1'b1) : rem;
    end

    // Next-state, operand latching and result fixup
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    is_mul_d = op[0];
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    // 0x80000000 negates to itself, read back as unsigned 2^31
                    a_mag_d  = a_neg ? (~a + 1'b1) : a;
                    b_mag_d  = b_neg ? (~b + 1'b1) : b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = is_mul_q ? mul_next : div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (is_mul_q) begin
                    if (sign_a_q ^ sign_b_q) begin
                        {hi_d, lo_d} = ~acc_q + 1'b1;
                    end else begin
                        {hi_d, lo_d} = acc_q;
                    end
                end else if (b_mag_q == '0) begin
                    // forced divide-by-zero result, quotient not sign-corrected
                    lo_d = '1;
                    hi_d = rem_fix;
                end else begin
                    lo_d = (sign_a_q ^ sign_b_q) ? (~quo + 1'b1) : quo;
                    hi_d = rem_fix;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_iter.sv
// Scoreboard bench for mips_cpu_muldiv_iter: expected {hi,lo} and issue cycle
// are queued at each accepted start and checked when done pulses.
module tb_mips_cpu_muldiv_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_run = 0;
    logic prev_done = 1'b0;

    logic [63:0] exp_q[$];
    int          st_q[$];

    mips_cpu_muldiv_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // independent reference using native 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] res;
        logic [31:0] q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (o)
            2'b01: res = {32'b0, x} * {32'b0, y};
            2'b11: res = 64'(sx * sy);
            2'b00: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    q = 32'(sx / sy);
                    r = 32'(sx % sy);
                    res = {r, q};
                end
            end
        endcase
        return res;
    endfunction

    // output monitor: pops scoreboard on done, checks latency/busy/pulse width
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                chk("result", {hi_out, lo_out}, exp_q.pop_front());
                chk("latency", 64'(cyc - st_q.pop_front()), 64'd33);
                chk("busy_run", 64'(busy_run), 64'd33);
                chk("busy_done_excl", {63'b0, busy}, 64'd0);
            end
        end
        if (prev_done) chk("done_pulse", {63'b0, done}, 64'd0);
        prev_done <= done;
        busy_run  <= busy ? busy_run + 1 : 0;
    end

    // drive one start at the current (negedge) time and record expectation
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        st_q.push_back(cyc);
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    // returns at the negedge of the done cycle, or flags a timeout
    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    logic [31:0] ra, rb;
    logic [1:0]  ro;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hilo", {hi_out, lo_out}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_done("multu_max");
        @(negedge clk);
        issue(2'b11, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        wait_done("mult_neg");
        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done("div_neg");
        @(negedge clk);
        issue(2'b00, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        wait_done("divu");
        @(negedge clk);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        wait_done("div_ovf");
        @(negedge clk);
        issue(2'b00, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        wait_done("divu_zero");
        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF);
        wait_done("div_zero");
        @(negedge clk);

        // stray start with new operands mid-CALC must be ignored
        issue(2'b00, 32'd1000, 32'd3, 64'h0000_0001_0000_014D);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op = 2'b11;
        a = 32'h1111_1111;
        b = 32'h2222_2222;
        @(negedge clk);
        start = 1'b0;
        wait_done("robust");
        // back-to-back: start asserted in the DONE cycle
        issue(2'b10, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2);
        wait_done("b2b");
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (i == 2) rb = 32'd0;
            if (i == 3) ra = 32'h8000_0000;
            if (i == 4) rb = 32'h8000_0000;
            if (i == 5) rb = 32'($urandom_range(1, 255));
            issue(ro, ra, rb, model(ro, ra, rb));
            wait_done("rand");
            if (i % 2 == 0) @(negedge clk);
        end
        @(negedge clk);

        // reset on cycle 10 of CALC aborts with no done pulse
        issue(2'b01, 32'd12345, 32'd6789, model(2'b01, 32'd12345, 32'd6789));
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        st_q.delete();
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_hilo", {hi_out, lo_out}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_hilo_hold", {hi_out, lo_out}, 64'd0);

        issue(2'b11, 32'h7FFF_FFFF, 32'h8000_0000, model(2'b11, 32'h7FFF_FFFF, 32'h8000_0000));
        wait_done("post_reset");
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv_iter.md
# mips_cpu_muldiv_iter

Multi-cycle iterative multiply/divide engine that computes MULT, MULTU, DIV and DIVU results over 34 clock cycles. It replaces single-cycle combinational arithmetic with a shift-add multiplier and a restoring divider. It sits between the execute-stage decode and the HI/LO register block. A start/busy/done handshake drives stall control, and the registered hi/lo results are written into HI/LO on `done`.

## Interface

Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported; results are 2×WIDTH.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a new operation; sampled only when the engine is idle or done
- `op`  in  2  operation code: 00 DIVU, 01 MULTU, 10 DIV, 11 MULT
- `a`  in  32  rs operand (dividend / multiplicand)
- `b`  in  32  rt operand (divisor / multiplier)
- `busy`  out  1  high while an operation is in flight; used as the pipeline stall source
- `done`  out  1  one-cycle pulse; `hi_out`/`lo_out` are valid with it
- `hi_out`  out  32  upper product / remainder
- `lo_out`  out  32  lower product / quotient

## Operation

- States: IDLE, CALC, FIXUP, DONE.
- **Reset:** state IDLE; `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0, iteration counter=0. Reset takes priority over all other inputs, including mid-operation; any in-flight result is discarded.
- **IDLE:**
  - `start`=1: latch `op`; latch the sign flags (signed ops only) from `a[31]` and `b[31]`; latch the magnitudes |a| and |b| (raw values for unsigned ops); clear the accumulator; counter=0; go to CALC.
  - `start`=0: stay in IDLE.
- **CALC:** one iteration per cycle; counter counts 0..31; at counter=31 go to FIXUP.
  - Multiply: 64-bit accumulator, shift-add, LSB-first over the multiplier.
  - Divide: restoring. Shift the {remainder, quotient} pair left by 1. Trial-subtract the divisor from the 33-bit partial remainder. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
- **FIXUP:** apply sign correction for signed ops.
  - MULT: negate the 64-bit product (two's complement) if the signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if the dividend was negative (truncation toward zero).
  - Register the results into `hi_out`/`lo_out`. Go to DONE.
- **DONE:** `done`=1 for exactly this cycle.
  - `start`=1: accept a new operation exactly as IDLE does (back-to-back issue).
  - `start`=0: go to IDLE.
- `start` is ignored in CALC and FIXUP.
- `a`, `b` and `op` may change freely after the sampling edge.
- `hi_out`/`lo_out` hold their last result until the next FIXUP. Only FIXUP and reset change them.
- Arithmetic rules:
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit.
  - Multiply results are the full 64 bits, with no truncation.
- Divide by zero (b=0, signed or unsigned): `lo_out`=0xFFFFFFFF, `hi_out`=`a` as sampled. Same latency; no sign fixup on this forced result.
- DIV 0x80000000 / 0xFFFFFFFF: `lo_out`=0x80000000, `hi_out`=0.

## Timing

- Let E0 be the edge at which `start` is sampled.
- `busy`=1 in the cycles following E0 through E33; `busy` is combinationally derived from state ∈ {CALC, FIXUP}.
- CALC occupies the 32 cycles following E0..E31. FIXUP follows E32. DONE follows E33.
- `done` rises 33 edges after E0 and stays high for 1 cycle. `hi_out`/`lo_out` update at that same edge.
- `busy` and `done` are never high simultaneously.
- Throughput: one operation per 34 cycles with back-to-back `start`.
- Reset asserted at any edge: IDLE and outputs zero at that edge. No `done` pulse for the aborted operation.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi_out`=0xFFFFFFFE, `lo_out`=0x00000001; `done` exactly 33 edges after `start`; `busy` high for 33 cycles.
- MULT −3 (0xFFFFFFFD) × 5 → `hi_out`=0xFFFFFFFF, `lo_out`=0xFFFFFFF1. DIV −7 / 2 → `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF.
- DIVU 100 / 7 → `lo_out`=0x0000000E, `hi_out`=0x00000002. DIV 0x80000000 / 0xFFFFFFFF → `lo_out`=0x80000000, `hi_out`=0.
- DIVU 0x1234 / 0 → `lo_out`=0xFFFFFFFF, `hi_out`=0x00001234, with normal latency.
- Operand/`start` robustness:
  - Change `a`/`b`/`op` and pulse `start` during CALC: the result is unchanged and the extra start is ignored.
  - Assert `start` in the DONE cycle: a second operation begins, and its `done` comes 33 edges later.
- Reset on cycle 10 of CALC: `busy`=0, `hi_out`=`lo_out`=0, and no `done` pulse follows. A new `start` then completes normally.
